// File: rtl/mem_access_unit.sv
// Load/store front end: turns one request into a single memory access and a one-cycle response.
// Optional macro MEM_ACCESS_MISALIGN_TRAP_EN: misaligned requests skip memory and respond with resp_misalign=1.
module mem_access_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [2:0]  resp_extmode,
    output logic        resp_misalign
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_n;
    logic        accept_c;
    logic        trap_c;
    logic [31:0] aligned_c;
    logic [3:0]  strobe_c;
    logic [31:0] wdata_c;
    logic [2:0]  ext_c;
    logic        we_q;
    logic [1:0]  off_q;
    logic [2:0]  ext_q;

    assign accept_c = req_valid && (state == IDLE);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic misalign_c;
    assign misalign_c = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign trap_c     = accept_c && misalign_c;
`else
    assign trap_c = 1'b0;
`endif

    // Request decode: size-aligned address, strobes, replicated store data, extension mode
    always_comb begin
        aligned_c = req_addr;
        strobe_c  = 4'b0000;
        wdata_c   = req_wdata;
        ext_c     = 3'b000;
        case (req_size)
            2'b00: begin
                wdata_c = {4{req_wdata[7:0]}};
                ext_c   = req_unsigned ? 3'b010 : 3'b001;
            end
            2'b01: begin
                aligned_c[0] = 1'b0;
                wdata_c      = {2{req_wdata[15:0]}};
                ext_c        = req_unsigned ? 3'b100 : 3'b011;
            end
            default: aligned_c[1:0] = 2'b00;
        endcase
        if (req_we) begin
            ext_c = 3'b000;
            case (req_size)
                2'b00:   strobe_c = 4'b0001 << aligned_c[1:0];
                2'b01:   strobe_c = 4'b0011 << {aligned_c[1], 1'b0};
                default: strobe_c = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept_c) state_n = trap_c ? RESP : ACCESS;
            ACCESS:  if (mem_ready) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs follow the next state so they line up with it exactly
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_ready    <= 1'b1;
            mem_en       <= 1'b0;
            mem_we       <= 4'b0000;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_extmode <= 3'b000;
            we_q         <= 1'b0;
            off_q        <= 2'b00;
            ext_q        <= 3'b000;
        end else begin
            req_ready  <= (state_n == IDLE);
            mem_en     <= (state_n == ACCESS);
            resp_valid <= (state_n == RESP);
            if (accept_c) begin
                we_q      <= req_we;
                off_q     <= aligned_c[1:0];
                ext_q     <= ext_c;
                mem_addr  <= {aligned_c[31:2], 2'b00};
                mem_wdata <= wdata_c;
            end
            if (state_n != ACCESS) mem_we <= 4'b0000;
            else if (accept_c)     mem_we <= strobe_c;
            if ((state == ACCESS) && mem_ready) begin
                resp_rdata   <= we_q ? 32'h0 : (mem_rdata >> {off_q, 3'b000});
                resp_extmode <= ext_q;
            end else if (trap_c) begin
                resp_rdata   <= 32'h0;
                resp_extmode <= ext_c;
            end
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    // Flag tracks the most recent response: set by a trap, cleared by a real access
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                              resp_misalign <= 1'b0;
        else if ((state == ACCESS) && mem_ready) resp_misalign <= 1'b0;
        else if (trap_c)                        resp_misalign <= 1'b1;
    end
`else
    assign resp_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a queue of expected responses popped at each resp_valid.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [2:0]  resp_extmode;
    logic        resp_misalign;

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  ext;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int unsigned total  = 0;
    int unsigned passed = 0;

    mem_access_unit dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_extmode (resp_extmode),
        .resp_misalign(resp_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, resp_rdata, e.rdata);
            chk({tag, "_extmode"}, 32'(resp_extmode), 32'(e.ext));
            chk({tag, "_misalign"}, 32'(resp_misalign), 32'(e.mis));
        end
    endtask

    task automatic run_access(input string tag, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int delay,
                              input logic [31:0] e_maddr, input logic [3:0] e_mwe,
                              input logic [31:0] e_mwdata, input logic [31:0] e_rdata,
                              input logic [2:0] e_ext);
        exp_t e;
        e.rdata = e_rdata;
        e.ext   = e_ext;
        e.mis   = 1'b0;
        sb.push_back(e);
        chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        // keep a different request on the bus; it must not disturb the access
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 2'($urandom);
        chk({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, e_maddr);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(e_mwe));
        if (we) chk({tag, "_mem_wdata"}, mem_wdata, e_mwdata);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({tag, "_wait_en"}, 32'(mem_en), 32'd1);
            chk({tag, "_wait_addr"}, mem_addr, e_maddr);
            chk({tag, "_wait_we"}, 32'(mem_we), 32'(e_mwe));
            chk({tag, "_wait_novalid"}, 32'(resp_valid), 32'd0);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        req_valid = 1'b0;
        check_resp(tag);
        chk({tag, "_resp_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_resp_mem_we"}, 32'(mem_we), 32'd0);
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
        chk({tag, "_hold_rdata"}, resp_rdata, e_rdata);
        chk({tag, "_hold_ext"}, 32'(resp_extmode), 32'(e_ext));
    endtask

    task automatic run_trap(input string tag, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [2:0] e_ext);
        exp_t e;
        e.rdata = 32'h0;
        e.ext   = e_ext;
        e.mis   = 1'b1;
        sb.push_back(e);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = 32'h0;
        mem_ready    = 1'b1;
        mem_rdata    = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check_resp(tag);
        @(negedge clk);
        mem_ready = 1'b0;
        chk({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
        chk({tag, "_mem_en_after"}, 32'(mem_en), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rstn         = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_rdata    = 32'h0;
        mem_ready    = 1'b0;
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_ext", 32'(resp_extmode), 32'd0);
        chk("rst_resp_mis", 32'(resp_misalign), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        run_access("lb", 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0,
                   32'h0000_1000, 4'b0000, 32'h0, 32'h0000_0080, 3'b001);
        run_access("sh", 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0,
                   32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0, 3'b000);
        run_access("lw", 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 3,
                   32'h0000_3000, 4'b0000, 32'h0, 32'hDEAD_BEEF, 3'b000);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        run_trap("lhu_mis", 2'b01, 1'b1, 32'h0000_4001, 3'b100);
        run_trap("lw_mis", 2'b10, 1'b0, 32'h0000_9002, 3'b000);
`else
        run_access("lhu_mis", 1'b0, 2'b01, 1'b1, 32'h0000_4001, 32'h0, 32'h1122_3344, 1,
                   32'h0000_4000, 4'b0000, 32'h0, 32'h1122_3344, 3'b100);
        run_access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h0000_9002, 32'h0, 32'hCAFE_F00D, 0,
                   32'h0000_9000, 4'b0000, 32'h0, 32'hCAFE_F00D, 3'b000);
`endif
        run_access("sb", 1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h7777_77A5, 32'h0, 0,
                   32'h0000_5000, 4'b0010, 32'hA5A5_A5A5, 32'h0, 3'b000);
        run_access("lh", 1'b0, 2'b01, 1'b0, 32'h0000_6002, 32'h0, 32'h8001_FFFF, 0,
                   32'h0000_6000, 4'b0000, 32'h0, 32'h0000_8001, 3'b011);
        run_access("lbu", 1'b0, 2'b00, 1'b1, 32'h0000_7002, 32'h0, 32'h00C3_0000, 2,
                   32'h0000_7000, 4'b0000, 32'h0, 32'h0000_00C3, 3'b010);
        run_access("sw11", 1'b1, 2'b11, 1'b0, 32'h0000_8000, 32'h0BAD_C0DE, 32'h0, 1,
                   32'h0000_8000, 4'b1111, 32'h0BAD_C0DE, 32'h0, 3'b000);

        // reset while an access is outstanding, memory answers late
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h0000_A000;
        req_wdata = 32'h1357_9BDF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmid_mem_en_before", 32'(mem_en), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rmid_mem_en", 32'(mem_en), 32'd0);
        chk("rmid_mem_we", 32'(mem_we), 32'd0);
        chk("rmid_mem_addr", mem_addr, 32'h0);
        chk("rmid_mem_wdata", mem_wdata, 32'h0);
        chk("rmid_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 32'h2468_ACE0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rmid_late_novalid", 32'(resp_valid), 32'd0);
        chk("rmid_ready", 32'(req_ready), 32'd1);
        chk("rmid_late_mem_en", 32'(mem_en), 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rmid_still_novalid", 32'(resp_valid), 32'd0);
        chk("rmid_rdata", resp_rdata, 32'h0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rstn  input  1  reset, asynchronous, active-low.
REQ-003 req_valid  input  1  load/store request present.
REQ-004 req_ready  output  1  unit can accept a request.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 req_unsigned  input  1  load zero-extends, not sign-extends; ignored for word and store.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 mem_en  output  1  memory access active.
REQ-011 mem_we  output  4  byte write strobes; 0000 for loads.
REQ-012 mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-013 mem_wdata  output  32  lane-replicated store data.
REQ-014 mem_rdata  input  32  read word; valid when mem_ready=1.
REQ-015 mem_ready  input  1  memory completes the access this cycle.
REQ-016 resp_valid  output  1  one-cycle response pulse.
REQ-017 resp_rdata  output  32  load data shifted so the addressed byte or half sits at bit 0; feeds the load-extension stage.
REQ-018 resp_extmode  output  3  000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned.
REQ-019 resp_misalign  output  1  request was misaligned.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 On req_valid&&req_ready, the unit SHALL register we/size/unsigned/addr/wdata and enter ACCESS next cycle.
REQ-022 In ACCESS, mem_en SHALL be 1 with mem_addr/mem_we/mem_wdata held stable until the cycle mem_ready=1; outside ACCESS mem_en=0 and mem_we=0000.
REQ-023 On the mem_ready cycle the unit SHALL capture mem_rdata >> (8*addr[1:0]) into resp_rdata and enter RESP; minimum latency is accept at cycle N, resp_valid at cycle N+2.
REQ-024 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; back-to-back requests are accepted no sooner than the following IDLE cycle.
REQ-025 Store strobes SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-026 Store data SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-027 Stores SHALL also pulse resp_valid, with resp_rdata=0 and resp_extmode=000.
REQ-028 Loads SHALL set resp_extmode from size/unsigned per REQ-018; resp_rdata and resp_extmode SHALL hold their values until the next response.
REQ-029 Misalignment SHALL be defined as half with addr[0]=1, or word with addr[1:0]!=00.
REQ-030 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-031 Assertion of rstn=0 SHALL immediately force state IDLE, mem_en=0, mem_we=0000, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_extmode=000, resp_misalign=0; req_ready=1 after release.
REQ-032 A reset during ACCESS SHALL abandon the access with no response; a mem_ready arriving afterwards SHALL be ignored.

Configuration
REQ-033 Macro MEM_ACCESS_MISALIGN_TRAP_EN: when defined, a misaligned request SHALL skip ACCESS (mem_en stays 0) and go directly to RESP with resp_misalign=1, resp_rdata=0, and resp_extmode from the request.
REQ-034 Without it, low address bits SHALL be cleared to size alignment (half: addr[0]=0; word: addr[1:0]=00) before use, the access proceeds normally, and resp_misalign SHALL be tied 0.

Verification
REQ-035 lb, addr 0x1003, mem_rdata 0x80AABBCC, mem_ready on first ACCESS cycle -> resp_valid at accept+2, resp_rdata=0x00000080, extmode=001.
REQ-036 sh, addr 0x2002, wdata 0x1234ABCD -> mem_addr=0x2000, mem_we=1100, mem_wdata=0xABCDABCD; response rdata=0.
REQ-037 lw, addr 0x3000, mem_ready delayed 3 cycles -> mem_en held 3 cycles with stable addr; resp_valid exactly once, rdata=mem_rdata.
REQ-038 lhu, addr 0x4001: with macro -> mem_en never asserted, resp_misalign=1, rdata=0; without macro -> mem_addr=0x4000, half at bits 15:0, extmode=100.
REQ-039 rstn low mid-ACCESS, then mem_ready=1 -> no resp_valid, mem_en=0 immediately, req_ready=1 after release.
